// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-detecting masked interrupt collector with claim/complete handshake and lost-edge counter
module irq_ctrl #(
  parameter int NUM_IRQ = 4,
  parameter int OVF_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IRQ-1:0]         irq_in,
  input  logic                       mask_we,
  input  logic [NUM_IRQ-1:0]         mask_wdata,
  input  logic                       claim,
  input  logic                       complete,
  output logic                       irq_out,
  output logic                       claim_valid,
  output logic [$clog2(NUM_IRQ)-1:0] claim_id,
  output logic [OVF_WIDTH-1:0]       overflow_count
);
  localparam int IW = $clog2(NUM_IRQ);
  typedef enum logic {IDLE, SERVICING} state_t;
  state_t state, state_n;
  logic [NUM_IRQ-1:0] prev, pending, mask, rise, eligible, clr, lost;
  logic [IW-1:0] sel;
  logic take;
  assign rise = irq_in & ~prev;
  assign eligible = pending & mask;
  assign take = state == IDLE && claim && |eligible;
  assign clr = take ? NUM_IRQ'(1) << sel : '0;
  assign lost = rise & pending & ~clr;
  assign irq_out = state == IDLE && |eligible;
  assign claim_valid = state == SERVICING;
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) sel = eligible[i] ? IW'(i) : sel;
  end
  always_comb state_n = take ? SERVICING : (state == SERVICING && complete) ? IDLE : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prev <= '0;
      pending <= '0;
      mask <= '1;
      claim_id <= '0;
      overflow_count <= '0;
    end else begin
      state <= state_n;
      prev <= irq_in;
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
      if (take) claim_id <= sel;
      if (|lost && !(&overflow_count)) overflow_count <= overflow_count + OVF_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed vector table, corner-case sequences and randomized run against a rule-level model
module tb_irq_ctrl;
  localparam int NQ = 4;
  localparam int OW = 4;
  localparam int OMAX = (1 << OW) - 1;
  logic clk = 0;
  logic reset = 1;
  logic [NQ-1:0] irq_in = '0;
  logic mask_we = 0;
  logic [NQ-1:0] mask_wdata = '0;
  logic claim = 0;
  logic complete = 0;
  logic irq_out, claim_valid;
  logic [1:0] claim_id;
  logic [OW-1:0] overflow_count;
  int checks = 0;
  int errors = 0;
  irq_ctrl #(.NUM_IRQ(NQ), .OVF_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .claim(claim), .complete(complete), .irq_out(irq_out), .claim_valid(claim_valid),
    .claim_id(claim_id), .overflow_count(overflow_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit rst;
    bit [NQ-1:0] irq;
    bit mwe;
    bit [NQ-1:0] mw;
    bit clm;
    bit cmp;
    bit io;
    bit cv;
    int cid;
    int ovf;
  } vec_t;
  vec_t vecs[$];
  bit mp[NQ], mm[NQ], mpv[NQ];
  bit mbusy;
  int mid, mov;
  task automatic add(bit rst, bit [NQ-1:0] irq, bit mwe, bit [NQ-1:0] mw, bit clm, bit cmp,
                     bit io, bit cv, int cid, int ovf);
    vec_t v;
    v.rst = rst; v.irq = irq; v.mwe = mwe; v.mw = mw; v.clm = clm; v.cmp = cmp;
    v.io = io; v.cv = cv; v.cid = cid; v.ovf = ovf;
    vecs.push_back(v);
  endtask
  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic model_step();
    int e;
    bit took, anylost, r, c;
    if (reset) begin
      for (int i = 0; i < NQ; i++) begin mp[i] = 0; mm[i] = 1; mpv[i] = 0; end
      mbusy = 0; mid = 0; mov = 0;
      return;
    end
    e = -1;
    for (int i = NQ - 1; i >= 0; i--) if (mp[i] && mm[i]) e = i;
    took = !mbusy && claim && e >= 0;
    anylost = 0;
    for (int i = 0; i < NQ; i++) begin
      r = irq_in[i] && !mpv[i];
      c = took && e == i;
      if (r && mp[i] && !c) anylost = 1;
      if (r) mp[i] = 1;
      else if (c) mp[i] = 0;
    end
    if (anylost && mov < OMAX) mov++;
    if (took) begin mbusy = 1; mid = e; end
    else if (mbusy && complete) mbusy = 0;
    for (int i = 0; i < NQ; i++) begin
      if (mask_we) mm[i] = mask_wdata[i];
      mpv[i] = irq_in[i];
    end
  endtask
  function automatic bit model_io();
    bit any = 0;
    for (int i = 0; i < NQ; i++) any |= mp[i] & mm[i];
    return !mbusy && any;
  endfunction
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic drive(bit rst, bit [NQ-1:0] irq, bit mwe, bit [NQ-1:0] mw, bit clm, bit cmp);
    reset = rst; irq_in = irq; mask_we = mwe; mask_wdata = mw; claim = clm; complete = cmp;
  endtask
  initial begin
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0001, 0, 4'b0000, 0, 0, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 0, 0, 0, 0);
    add(0, 4'b0110, 0, 4'b0000, 0, 0, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 1, 1, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 1, 0, 1, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 1, 2, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 0, 0, 2, 0);
    add(0, 4'b0000, 1, 4'b1110, 0, 0, 0, 0, 2, 0);
    add(0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 2, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 2, 0);
    add(0, 4'b0000, 1, 4'b1111, 0, 0, 1, 0, 2, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 0, 0, 0, 0);
    add(0, 4'b1000, 0, 4'b0000, 0, 0, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0, 0);
    add(0, 4'b1000, 0, 4'b0000, 0, 0, 1, 0, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0, 1);
    add(0, 4'b1000, 0, 4'b0000, 0, 0, 1, 0, 0, 2);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 1, 3, 2);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 0, 0, 3, 2);
    add(0, 4'b1000, 0, 4'b0000, 0, 0, 1, 0, 3, 2);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 3, 2);
    add(0, 4'b1000, 0, 4'b0000, 1, 0, 0, 1, 3, 2);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 1, 0, 3, 2);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 1, 3, 2);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 0, 0, 3, 2);
    add(0, 4'b0100, 0, 4'b0000, 0, 0, 1, 0, 3, 2);
    add(0, 4'b0000, 0, 4'b0000, 1, 1, 0, 1, 2, 2);
    add(0, 4'b0000, 0, 4'b0000, 1, 1, 0, 0, 2, 2);
    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].irq, vecs[k].mwe, vecs[k].mw, vecs[k].clm, vecs[k].cmp);
      tick();
      check($sformatf("vec%0d irq_out", k), int'(irq_out), int'(vecs[k].io));
      check($sformatf("vec%0d claim_valid", k), int'(claim_valid), int'(vecs[k].cv));
      check($sformatf("vec%0d claim_id", k), int'(claim_id), vecs[k].cid);
      check($sformatf("vec%0d overflow_count", k), int'(overflow_count), vecs[k].ovf);
    end
    drive(0, 4'b1000, 0, 4'b0000, 0, 0);
    tick();
    for (int n = 1; n <= 20; n++) begin
      drive(0, 4'b0000, 0, 4'b0000, 0, 0);
      tick();
      drive(0, 4'b1000, 0, 4'b0000, 0, 0);
      tick();
      if (n == 12) check("ovf_after_12_lost", int'(overflow_count), 14);
    end
    check("ovf_saturated", int'(overflow_count), OMAX);
    drive(0, 4'b0001, 0, 4'b0000, 0, 0);
    tick();
    drive(0, 4'b0001, 0, 4'b0000, 1, 0);
    tick();
    check("pre_reset claim_valid", int'(claim_valid), 1);
    check("pre_reset claim_id", int'(claim_id), 0);
    drive(1, 4'b0001, 0, 4'b0000, 0, 0);
    tick();
    check("mid_reset claim_valid", int'(claim_valid), 0);
    check("mid_reset overflow_count", int'(overflow_count), 0);
    check("mid_reset irq_out", int'(irq_out), 0);
    drive(0, 4'b0001, 0, 4'b0000, 0, 0);
    tick();
    check("post_reset held_line irq_out", int'(irq_out), 1);
    drive(0, 4'b1000, 0, 4'b0000, 1, 0);
    tick();
    check("post_reset claim_id", int'(claim_id), 0);
    drive(0, 4'b1000, 0, 4'b0000, 0, 1);
    tick();
    check("post_reset mask_all_ones line3", int'(irq_out), 1);
    drive(0, 4'b0110, 0, 4'b0000, 0, 0);
    tick();
    drive(0, 4'b0000, 0, 4'b0000, 0, 0);
    tick();
    drive(0, 4'b0110, 0, 4'b0000, 0, 0);
    tick();
    check("two_lost_one_cycle ovf", int'(overflow_count), 1);
    drive(1, 4'b0000, 0, 4'b0000, 0, 0);
    tick();
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 63) == 0, NQ'($urandom), $urandom_range(0, 7) == 0, NQ'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      tick();
      check($sformatf("rnd%0d irq_out", n), int'(irq_out), int'(model_io()));
      check($sformatf("rnd%0d claim_valid", n), int'(claim_valid), int'(mbusy));
      check($sformatf("rnd%0d claim_id", n), int'(claim_id), mid);
      check($sformatf("rnd%0d overflow_count", n), int'(overflow_count), mov);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt collector sitting directly downstream of the programmable interval timer. It edge-detects up to NUM_IRQ interrupt lines: the timer's `interrupting` pulse on line 0, with spare lines for future sources. Detected edges are latched as pending bits, gated by a mask, and presented to a host (pin-driven or JTAG-driven) through a single `irq_out` plus a claim/complete handshake. Edges lost because a source was already pending are counted in a saturating overflow counter.

## Interface
Parameters:
- NUM_IRQ, 4: number of interrupt inputs; legal range 2..8.
- OVF_WIDTH, 4: width of overflow counter.

Ports:
- Single clock, `clk`; synchronous active-high reset, `reset` (polarity and synchronicity fixed).
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  interrupt request levels; bit 0 = timer `interrupting`.
- mask_we  in  1  write strobe for mask register.
- mask_wdata  in  NUM_IRQ  new mask value; 1 = enabled.
- claim  in  1  host claims highest-priority pending interrupt (single-cycle pulse).
- complete  in  1  host finishes servicing the claimed interrupt.
- irq_out  out  1  interrupt request to host.
- claim_valid  out  1  high while an interrupt is claimed (SERVICING).
- claim_id  out  clog2(NUM_IRQ)  index of claimed source; valid while claim_valid.
- overflow_count  out  OVF_WIDTH  saturating count of lost edges.

## Operation
- Edge detect: register `prev` per line. `rise[i] = irq_in[i] & ~prev[i]`. `prev <= irq_in` every cycle.
- Pending: `pending[i]` is set on `rise[i]` and cleared when source i is claimed. Set wins over clear in the same cycle.
- Mask: `mask <= mask_wdata` on mask_we.
  - Masked sources still latch pending; they only stop contributing to irq_out and to claim selection.
  - Unmasking a pending source raises irq_out on the next cycle.
- `eligible = pending & mask`. Selection is the lowest index of eligible (bit 0 highest priority).
- FSM, two states:
  - IDLE: `irq_out = |eligible`. `claim` with eligible nonzero: latch `claim_id` = selected index, clear that pending bit, go to SERVICING. `claim` with eligible zero is ignored.
  - SERVICING: irq_out = 0, claim_valid = 1, claim_id held. `complete` returns to IDLE. `claim` is ignored.
- `complete` in IDLE is ignored. `claim` and `complete` in the same cycle are evaluated against the current state only: IDLE takes the claim; SERVICING takes the complete.
- New edges during SERVICING, including on the serviced source, set pending normally and are presented after return to IDLE.
- Overflow:
  - Counted when a rise arrives while `pending[i]` is already 1 and that bit is not being cleared by a claim in the same cycle.
  - The counter increments by exactly 1 per cycle in which any source loses an edge, even if several sources do.
  - It saturates at all-ones and clears only on reset.
- Outputs are functions of registers only; there is no combinational path from any input to any output.

## Timing
- Reset values:
  - state IDLE, pending 0, prev 0, mask all-ones, claim_id 0, overflow_count 0.
  - Resulting outputs: irq_out 0, claim_valid 0.
- A line held high through reset produces a rise on the first cycle after reset deasserts.
- Latency from irq_in rising in cycle N to irq_out high is cycle N+1.
- From claim sampled in cycle N: claim_valid and claim_id are valid from N+1, and irq_out is low from N+1.
- From complete sampled in cycle N: state is IDLE in N+1, and irq_out reflects remaining eligible bits in N+1.
- Back-to-back interrupts: the minimum service loop is 2 cycles (claim, complete).
- Reset mid-service returns to IDLE immediately and discards all pending bits and claims.

## Test plan
- Single timer pulse: irq_in=4'b0001 for 1 cycle at cycle 5 -> irq_out=1 at cycle 6. Claim at 8 -> claim_valid=1, claim_id=0 at 9, irq_out=0. Complete at 10 -> irq_out stays 0 at 11.
- Priority: rises on lines 2 and 1 in the same cycle, then claim twice with complete between -> claim_id=1 first, then 2. irq_out stays 1 between services until both are claimed.
- Masking: mask_wdata=4'b1110 written, rise on line 0 -> irq_out stays 0, pending[0]=1. Write mask 4'b1111 -> irq_out=1 next cycle.
- Overflow: three rises on line 3 with no claim -> overflow_count=2. Then 20 more lost edges with OVF_WIDTH=4 -> count saturates at 15.
- Simultaneous rise and claim of the same source -> pending stays 1, overflow_count unchanged. After complete, irq_out=1 and second claim_id=that source.
- Reset mid-service with irq_in[0] held high -> after reset: claim_valid=0, overflow_count=0, mask=4'b1111. Rise detected on the first post-reset cycle, so irq_out=1 one cycle later.
